// File: rtl/t01_line_clear.sv
// Row-clear engine for the Tetris playfield: captures the locked grid, scans it
// bottom to top, and collapses every full row by shifting the rows above it down.
module t01_line_clear #(
    parameter int ROWS  = 20,
    parameter int COLS  = 10,
    parameter int CBITS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ROWS*COLS*CBITS-1:0]   grid_in,
    output logic [ROWS*COLS*CBITS-1:0]   grid_out,
    output logic                         busy,
    output logic                         done,
    output logic [4:0]                   lines_cleared
);

    localparam int RW = COLS * CBITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [4:0]                    r_row;
    logic [ROWS*COLS*CBITS-1:0]    r_grid;
    logic [4:0]                    r_lines;
    logic                          r_busy;
    logic                          r_done;
    logic                          w_row_full;

    assign grid_out      = r_grid;
    assign lines_cleared = r_lines;
    assign busy          = r_busy;
    assign done          = r_done;

    // A row is full when no cell in it holds the empty color.
    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch is inferred.
        w_row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (r_grid[(int'(r_row) * COLS + c) * CBITS +: CBITS] == '0) begin
                w_row_full = 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SCAN;
            S_SCAN: begin
                if (w_row_full)          w_next_state = S_SHIFT;
                else if (r_row == 5'd0)  w_next_state = S_DONE;
            end
            S_SHIFT: w_next_state = S_SCAN;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grid  <= '0;
            r_lines <= '0;
            r_row   <= 5'(ROWS - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_grid  <= grid_in;
                        r_lines <= '0;
                        r_row   <= 5'(ROWS - 1);
                    end
                end
                S_SCAN: begin
                    if (!w_row_full && r_row != 5'd0) begin
                        r_row <= r_row - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // Row r stays put so the row dropped into it is rescanned.
                    for (int i = 0; i < ROWS; i++) begin
                        if (i <= int'(r_row)) begin
                            if (i == 0) r_grid[0 +: RW] <= '0;
                            else        r_grid[i*RW +: RW] <= r_grid[(i-1)*RW +: RW];
                        end
                    end
                    r_lines <= r_lines + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_t01_line_clear.sv
// Scoreboard bench for the row-clear engine: a compaction model predicts the
// result grid, clear count and done latency of every accepted start.
module tb_t01_line_clear;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int CBITS = 3;
    localparam int GW    = ROWS * COLS * CBITS;
    localparam int RW    = COLS * CBITS;

    typedef logic [GW-1:0] grid_t;

    typedef struct {
        grid_t      grid;
        logic [4:0] lines;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    grid_t      grid_in;
    grid_t      grid_out;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    t01_line_clear #(.ROWS(ROWS), .COLS(COLS), .CBITS(CBITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .grid_in       (grid_in),
        .grid_out      (grid_out),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input grid_t obs, input grid_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic grid_t set_cell(input grid_t g, input int r, input int c,
                                       input logic [2:0] v);
        grid_t t = g;
        t[(r * COLS + c) * CBITS +: CBITS] = v;
        return t;
    endfunction

    function automatic grid_t fill_row(input grid_t g, input int r, input logic [2:0] v);
        grid_t t = g;
        for (int c = 0; c < COLS; c++) t = set_cell(t, r, c, v);
        return t;
    endfunction

    // Reference: keep non-full rows in bottom-to-top order, pack them at the bottom.
    function automatic exp_t model(input grid_t g);
        exp_t e;
        int   dst = ROWS - 1;
        int   k   = 0;
        bit   full;
        e.grid = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (g[(r * COLS + c) * CBITS +: CBITS] == 3'b000) full = 1'b0;
            if (full) k++;
            else begin
                e.grid[dst*RW +: RW] = g[r*RW +: RW];
                dst--;
            end
        end
        e.lines = 5'(k);
        e.lat   = ROWS + 2 * k;
        return e;
    endfunction

    function automatic grid_t rand_grid();
        grid_t g = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int c = 0; c < COLS; c++) g = set_cell(g, r, c, 3'($urandom_range(1, 7)));
            end else begin
                for (int c = 0; c < COLS; c++) g = set_cell(g, r, c, 3'($urandom_range(0, 7)));
                g = set_cell(g, r, $urandom_range(0, COLS - 1), 3'b000);
            end
        end
        return g;
    endfunction

    task automatic scramble_input();
        for (int k = 0; k < ROWS * COLS; k++) grid_in[k*CBITS +: CBITS] = 3'($urandom_range(0, 7));
    endtask

    // One operation; mid_at > 0 re-pulses start (with fresh grid_in) at that edge.
    task automatic run_op(input grid_t g, input string name, input int mid_at);
        exp_t e;
        int   edges    = 0;
        int   busy_cnt = 0;
        @(negedge clk);
        grid_in = g;
        start   = 1'b1;
        sb.push_back(model(g));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        scramble_input();
        while (1) begin
            if (busy) busy_cnt++;
            if (done || edges >= 100) break;
            start = (edges + 1 == mid_at);
            if (start) scramble_input();
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        check({name, " latency"}, grid_t'(edges), grid_t'(e.lat));
        check({name, " grid"}, grid_out, e.grid);
        check({name, " lines"}, grid_t'(lines_cleared), grid_t'(e.lines));
        check({name, " busy_cycles"}, grid_t'(busy_cnt), grid_t'(e.lat + 1));
        @(negedge clk);
        check({name, " done_pulse"}, grid_t'(done), grid_t'(0));
        check({name, " idle_busy"}, grid_t'(busy), grid_t'(0));
        repeat (3) @(negedge clk);
        check({name, " hold_grid"}, grid_out, e.grid);
        check({name, " hold_lines"}, grid_t'(lines_cleared), grid_t'(e.lines));
    endtask

    task automatic reset_mid_shift();
        bit saw_done = 1'b0;
        @(negedge clk);
        grid_in = fill_row('0, ROWS - 1, 3'b101);
        start   = 1'b1;
        @(posedge clk);             // edge 0: enter SCAN on row 19
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);             // edge 1: row 19 full, enter SHIFT
        @(negedge clk);
        check("rst pre busy", grid_t'(busy), grid_t'(1));
        rst = 1'b1;
        #1;
        check("rst grid", grid_out, '0);
        check("rst lines", grid_t'(lines_cleared), '0);
        check("rst busy", grid_t'(busy), '0);
        check("rst done", grid_t'(done), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("rst no done", grid_t'(saw_done), '0);
    endtask

    initial begin
        grid_t g;
        rst     = 1'b1;
        start   = 1'b0;
        grid_in = '0;
        #2;
        check("reset grid", grid_out, '0);
        check("reset lines", grid_t'(lines_cleared), '0);
        check("reset busy", grid_t'(busy), '0);
        check("reset done", grid_t'(done), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op('0, "empty", 0);

        g = set_cell(fill_row('0, 19, 3'b100), 18, 0, 3'b010);
        run_op(g, "row19", 0);

        g = '0;
        for (int r = 16; r < 20; r++) g = fill_row(g, r, 3'(r - 13));
        g = set_cell(g, 15, 9, 3'b111);
        run_op(g, "rows16_19", 0);
        run_op(g, "busy_start", 7);

        g = fill_row(fill_row('0, 19, 3'b011), 17, 3'b110);
        g = set_cell(g, 18, 5, 3'b001);
        run_op(g, "rows19_17", 0);

        run_op(fill_row('0, 0, 3'b001), "row0", 0);

        reset_mid_shift();
        run_op(g, "after_rst", 0);

        for (int i = 0; i < 6; i++) begin
            run_op(rand_grid(), $sformatf("rand%0d", i), (i % 2 == 1) ? 4 + 3 * i : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
